fsm_param_seq: RTL and testbench
================================

Name: fsm_param_seq

Overview:
- Parametrised successor to the two-state case-decoded FSM used in FSM-coverage diagnostics.
- Registered state machine with a configurable state count, state width and stepping mode.
- Adds directional stepping, forced loads, illegal-state detection, wrap pulses and a transition counter.
- Serves as a reusable DUT for FSM-coverage diags: state variable `state`, output `out_b`, declared transitions documented per mode below.

Parameters:
- STATE_W, 2: width of state register; NUM_STATES must be <= 2**STATE_W.
- NUM_STATES, 4: legal states 0..NUM_STATES-1; minimum 2.
- MODE, 1: 0 = toggle (0<->1 only, NUM_STATES ignored as 2); 1 = ring (wraps both directions); 2 = saturating up/down.
- CNT_W, 8: width of transition counter.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- go  input  1  step request, sampled each rising edge.
- dir  input  1  1 = step up, 0 = step down; ignored in MODE 0.
- force_vld  input  1  load force_state this cycle; has priority over go.
- force_state  input  STATE_W  value to load.
- state  output  STATE_W  current state, registered.
- out_b  output  1  Moore output: 1 when state==0, else 0 (the 1'b0->1'b1 mapping of the two-state case).
- wrap  output  1  one-cycle pulse, registered, on a ring wrap or a toggle 1->0.
- illegal  output  1  sticky flag: set on any attempt to reach state >= NUM_STATES.
- trans_cnt  output  CNT_W  count of accepted state changes, wraps modulo 2**CNT_W.

Behaviour:
- Reset (reset_n==0 at rising edge): state=0, out_b=1, wrap=0, illegal=0, trans_cnt=0. Reset overrides all inputs, including a step or force already in progress.
- Priority per edge: reset > force_vld > go > hold.
- force_vld with force_state < NUM_STATES:
  - state <= force_state.
  - trans_cnt increments only if force_state != state.
  - wrap=0.
- force_vld with force_state >= NUM_STATES:
  - state unchanged, illegal <= 1, trans_cnt unchanged.
- go, MODE 0: state <= ~state[0] (zero-extended); trans_cnt+1; wrap=1 when leaving state 1.
- go, MODE 1:
  - dir=1: state <= state+1, or 0 if state==NUM_STATES-1 (wrap=1).
  - dir=0: state <= state-1, or NUM_STATES-1 if state==0 (wrap=1).
  - trans_cnt+1 on every step.
- go, MODE 2:
  - dir=1 at NUM_STATES-1, or dir=0 at 0: hold; no count, no wrap. Otherwise step ±1 and trans_cnt+1.
- wrap is a single-cycle pulse; it is 0 on any cycle without a wrapping step.
- out_b is combinational from registered state, so it follows state with zero added latency.
- State change is visible on `state` one cycle after go or force_vld is sampled.
- illegal clears only on reset.
- If state is somehow >= NUM_STATES (e.g. after an X-injection diag):
  - go forces state <= 0 and sets illegal.
  - trans_cnt increments.
- trans_cnt at all-ones increments to 0; no saturation.
- Declared FSM transitions for coverage:
  - MODE 0: 0->1, 1->0.
  - MODE 1: i->i±1 plus both wrap arcs.
  - MODE 2: i->i±1 only.

Optional Feature:
- Macro: FSM_DWELL_EN.
- When defined:
  - An internal dwell counter clears on every state change.
  - go is accepted only once the counter reaches 2, i.e. state has been held for at least 2 cycles.
  - Earlier go requests are dropped silently; no queueing.
  - force_vld is never gated.
- When undefined: go is accepted on every cycle.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, then go=0 for 5 cycles -> state=0, out_b=1, trans_cnt=0, wrap=0, illegal=0 throughout.
- MODE 1, NUM_STATES=4, dir=1, go held for 5 cycles -> state sequence 1,2,3,0,1; wrap pulses once, in the cycle state shows 0; trans_cnt=5.
- MODE 2, dir=0 from state 0, go for 3 cycles -> state stays 0, trans_cnt=0, wrap=0; then dir=1 for 5 cycles -> 1,2,3,3,3, trans_cnt=3.
- force_vld with force_state=2 together with go=1 -> state=2 (force wins), trans_cnt+1; then force_state=3'd5 with STATE_W=3, NUM_STATES=5 -> state unchanged, illegal=1 until reset.
- MODE 0, go for 4 cycles -> state 1,0,1,0; out_b 0,1,0,1; wrap on the 2nd and 4th steps; reset_n=0 mid-sequence -> state=0 at the next edge.
- FSM_DWELL_EN defined, MODE 1, go held continuously -> state advances every 3rd cycle (0,0,0,1,1,1,2...); trans_cnt=2 after 7 accepted-window cycles.

Source files
------------

// File: rtl/fsm_param_seq.sv
// fsm_param_seq: parametrised stepping state machine for FSM-coverage diags.
// MODE 0 toggles between states 0 and 1, MODE 1 is a bidirectional ring,
// MODE 2 counts up/down and saturates at both ends. A forced load has
// priority over a step request. Attempts to reach a state outside
// 0..NUM_STATES-1 set a sticky illegal flag.
// Optional build macro FSM_DWELL_EN: a step request is accepted only after
// the state has been held for at least two cycles.
module fsm_param_seq #(
    parameter int STATE_W    = 2,
    parameter int NUM_STATES = 4,
    parameter int MODE       = 1,
    parameter int CNT_W      = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               go,
    input  logic               dir,
    input  logic               force_vld,
    input  logic [STATE_W-1:0] force_state,
    output logic [STATE_W-1:0] state,
    output logic               out_b,
    output logic               wrap,
    output logic               illegal,
    output logic [CNT_W-1:0]   trans_cnt
);

    // Toggle mode only ever uses two states, whatever NUM_STATES says.
    localparam int NS = (MODE == 0) ? 2 : NUM_STATES;
    // One extra bit so NS == 2**STATE_W stays representable.
    localparam logic [STATE_W:0]   NS_V = (STATE_W + 1)'(NS);
    localparam logic [STATE_W-1:0] LAST = STATE_W'(NS - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic               wrap_q, wrap_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               go_ok_s;
    logic               force_legal_s;
    logic               state_legal_s;

    assign force_legal_s = ({1'b0, force_state} < NS_V);
    assign state_legal_s = ({1'b0, state_q} < NS_V);

`ifdef FSM_DWELL_EN
    logic [1:0] dwell_q, dwell_d;

    assign go_ok_s = go && (dwell_q == 2'd2);

    // Dwell counter: restarts on every state change, saturates at 2.
    always_comb begin
        dwell_d = dwell_q;
        if (state_d != state_q) begin
            dwell_d = 2'd0;
        end else if (dwell_q != 2'd2) begin
            dwell_d = dwell_q + 2'd1;
        end else begin
            dwell_d = dwell_q;
        end
    end

    // Dwell counter register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            dwell_q <= 2'd0;
        end else begin
            dwell_q <= dwell_d;
        end
    end
`else
    assign go_ok_s = go;
`endif

    // Next-state decode: force beats step, step behaviour depends on MODE.
    always_comb begin
        state_d   = state_q;
        wrap_d    = 1'b0;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if (force_vld) begin
            if (force_legal_s) begin
                state_d = force_state;
                if (force_state != state_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                illegal_d = 1'b1;
            end
        end else if (go_ok_s) begin
            if (!state_legal_s) begin
                // Recover from a corrupted state register.
                state_d   = '0;
                illegal_d = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
            end else begin
                case (MODE)
                    0: begin
                        state_d    = '0;
                        state_d[0] = ~state_q[0];
                        wrap_d     = state_q[0];
                        cnt_d      = cnt_q + CNT_W'(1);
                    end
                    1: begin
                        if (dir) begin
                            if (state_q == LAST) begin
                                state_d = '0;
                                wrap_d  = 1'b1;
                            end else begin
                                state_d = state_q + STATE_W'(1);
                            end
                        end else begin
                            if (state_q == '0) begin
                                state_d = LAST;
                                wrap_d  = 1'b1;
                            end else begin
                                state_d = state_q - STATE_W'(1);
                            end
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    2: begin
                        if (dir && (state_q != LAST)) begin
                            state_d = state_q + STATE_W'(1);
                            cnt_d   = cnt_q + CNT_W'(1);
                        end else if (!dir && (state_q != '0)) begin
                            state_d = state_q - STATE_W'(1);
                            cnt_d   = cnt_q + CNT_W'(1);
                        end else begin
                            state_d = state_q;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, wrap pulse, sticky illegal flag and transition counter.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= '0;
            wrap_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wrap_q    <= wrap_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign state     = state_q;
    assign out_b     = (state_q == '0);
    assign wrap      = wrap_q;
    assign illegal   = illegal_q;
    assign trans_cnt = cnt_q;

endmodule

// File: tb/tb_fsm_param_seq.sv
// Scoreboard bench for fsm_param_seq: four instances (toggle, ring,
// saturating, ring with 3-bit state / 5 states) share one stimulus stream.
// A behavioural model pushes expected outputs when stimulus is driven; they
// are popped and compared after the clock edge.
module tb_fsm_param_seq;

    typedef struct packed {
        logic [2:0] st;
        logic       wr;
        logic       il;
        logic [7:0] cnt;
    } obs_t;
    typedef obs_t [3:0] obs4_t;

    localparam int MODE_OF [4] = '{0, 1, 2, 1};
    localparam int NS_OF   [4] = '{2, 4, 4, 5};

    logic       clock = 1'b0;
    logic       reset_n, go, dir, force_vld;
    logic [2:0] force_state;

    logic [1:0] st0, st1, st2;
    logic [2:0] st3;
    logic [3:0] ob, wr, il;
    logic [7:0] c0, c1, c2, c3;

    int    m_st [4];
    int    m_cnt[4];
    int    m_dw [4];
    logic  m_wr [4];
    logic  m_il [4];
    obs4_t sb_q[$];
    string nm [4] = '{"tog", "ring", "sat", "ring5"};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    fsm_param_seq #(.STATE_W(2), .NUM_STATES(4), .MODE(0), .CNT_W(8)) u_tog (
        .clock(clock), .reset_n(reset_n), .go(go), .dir(dir), .force_vld(force_vld),
        .force_state(force_state[1:0]), .state(st0), .out_b(ob[0]), .wrap(wr[0]),
        .illegal(il[0]), .trans_cnt(c0));
    fsm_param_seq #(.STATE_W(2), .NUM_STATES(4), .MODE(1), .CNT_W(8)) u_ring (
        .clock(clock), .reset_n(reset_n), .go(go), .dir(dir), .force_vld(force_vld),
        .force_state(force_state[1:0]), .state(st1), .out_b(ob[1]), .wrap(wr[1]),
        .illegal(il[1]), .trans_cnt(c1));
    fsm_param_seq #(.STATE_W(2), .NUM_STATES(4), .MODE(2), .CNT_W(8)) u_sat (
        .clock(clock), .reset_n(reset_n), .go(go), .dir(dir), .force_vld(force_vld),
        .force_state(force_state[1:0]), .state(st2), .out_b(ob[2]), .wrap(wr[2]),
        .illegal(il[2]), .trans_cnt(c2));
    fsm_param_seq #(.STATE_W(3), .NUM_STATES(5), .MODE(1), .CNT_W(8)) u_ring5 (
        .clock(clock), .reset_n(reset_n), .go(go), .dir(dir), .force_vld(force_vld),
        .force_state(force_state), .state(st3), .out_b(ob[3]), .wrap(wr[3]),
        .illegal(il[3]), .trans_cnt(c3));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model of one instance for one clock edge.
    task automatic model_step(input int k, input logic rn, input logic g, input logic d,
                              input logic fv, input logic [2:0] fs);
        int   s, nx, f, ns, md;
        logic acc, inc;
        s  = m_st[k];
        ns = NS_OF[k];
        md = MODE_OF[k];
        f  = (k == 3) ? int'(fs) : int'(fs[1:0]);
        m_wr[k] = 1'b0;
        nx  = s;
        inc = 1'b0;
        if (!rn) begin
            m_st[k] = 0; m_il[k] = 1'b0; m_cnt[k] = 0; m_dw[k] = 0;
            return;
        end
        acc = g;
`ifdef FSM_DWELL_EN
        acc = g && (m_dw[k] == 2);
`endif
        if (fv) begin
            if (f < ns) begin
                nx  = f;
                inc = (f != s);
            end else begin
                m_il[k] = 1'b1;
            end
        end else if (acc) begin
            if (s >= ns) begin
                nx = 0; m_il[k] = 1'b1; inc = 1'b1;
            end else if (md == 0) begin
                nx = (s == 1) ? 0 : 1; m_wr[k] = (s == 1); inc = 1'b1;
            end else if (md == 1) begin
                if (d) begin
                    nx = (s == ns - 1) ? 0 : s + 1; m_wr[k] = (s == ns - 1);
                end else begin
                    nx = (s == 0) ? ns - 1 : s - 1; m_wr[k] = (s == 0);
                end
                inc = 1'b1;
            end else begin
                if (d && s < ns - 1) begin
                    nx = s + 1; inc = 1'b1;
                end else if (!d && s > 0) begin
                    nx = s - 1; inc = 1'b1;
                end
            end
        end
        if (inc) m_cnt[k] = (m_cnt[k] + 1) % 256;
        if (nx != s) m_dw[k] = 0;
        else if (m_dw[k] < 2) m_dw[k] = m_dw[k] + 1;
        m_st[k] = nx;
    endtask

    // Drive one cycle of stimulus, push expectation, then check after the edge.
    task automatic cycle(input logic rn, input logic g, input logic d,
                         input logic fv, input logic [2:0] fs);
        obs4_t e, o;
        reset_n = rn; go = g; dir = d; force_vld = fv; force_state = fs;
        for (int k = 0; k < 4; k++) begin
            model_step(k, rn, g, d, fv, fs);
            e[k].st  = 3'(m_st[k]);
            e[k].wr  = m_wr[k];
            e[k].il  = m_il[k];
            e[k].cnt = 8'(m_cnt[k]);
        end
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        o[0] = '{st: {1'b0, st0}, wr: wr[0], il: il[0], cnt: c0};
        o[1] = '{st: {1'b0, st1}, wr: wr[1], il: il[1], cnt: c1};
        o[2] = '{st: {1'b0, st2}, wr: wr[2], il: il[2], cnt: c2};
        o[3] = '{st: st3,         wr: wr[3], il: il[3], cnt: c3};
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            for (int k = 0; k < 4; k++) begin
                check_eq({nm[k], ".state"},   32'(o[k].st),  32'(e[k].st));
                check_eq({nm[k], ".out_b"},   32'(ob[k]),    32'(e[k].st == 3'd0));
                check_eq({nm[k], ".wrap"},    32'(o[k].wr),  32'(e[k].wr));
                check_eq({nm[k], ".illegal"}, 32'(o[k].il),  32'(e[k].il));
                check_eq({nm[k], ".cnt"},     32'(o[k].cnt), 32'(e[k].cnt));
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; go = 1'b0; dir = 1'b0; force_vld = 1'b0; force_state = 3'd0;
        for (int k = 0; k < 4; k++) begin
            m_st[k] = 0; m_cnt[k] = 0; m_dw[k] = 0; m_wr[k] = 1'b0; m_il[k] = 1'b0;
        end
        #2;
        // Reset then idle.
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        // Step up five times: ring wraps, saturating sticks at top, toggle flips.
        repeat (5) cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        // Step down across zero.
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        // Saturation from a fresh reset: down at 0 holds, then up to the top.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        repeat (5) cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        // Force beats go; then out-of-range force sets illegal.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 3'd2);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 3'd2);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 3'd5);
        repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        // Reset in the middle of a stepping sequence.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd3);
        repeat (4) cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        // Randomised traffic with occasional resets and forces.
        for (int i = 0; i < 600; i++) begin
            cycle(1'b1 ^ ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0),
                  3'($urandom_range(0, 7)));
        end
        // Long run of steps from reset to carry the counter past all-ones.
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        repeat (300) cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
